// File: rtl/aes_enc_iter.sv
// rtl/aes_enc_iter.sv - iterative AES-128/256 encrypt core, ECB/CBC, one round per clock
// Leaf modules (S-box, ShiftRows, MixColumns) work on port byte order: byte i at [8i+7:8i].

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;
  logic [7:0] sq;

  // Multiplicative inverse as a^254 (zero maps to zero), then the affine transform.
  always_comb begin
    inv = 8'h01;
    sq  = a_i;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_shift_rows (
  input  logic [127:0] s_i,
  output logic [127:0] s_o
);
  // Byte 4c+r is row r, column c; row r rotates left by r columns.
  always_comb begin
    s_o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        s_o[8*(4*c+r) +: 8] = s_i[8*(4*((c+r)%4)+r) +: 8];
      end
    end
  end
endmodule

module aes_mix_cols (
  input  logic [127:0] s_i,
  output logic [127:0] s_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
    a0 = c[7:0];
    a1 = c[15:8];
    a2 = c[23:16];
    a3 = c[31:24];
    b0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    b3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    return {b3, b2, b1, b0};
  endfunction

  always_comb begin
    s_o = '0;
    for (int c = 0; c < 4; c++) begin
      s_o[32*c +: 32] = mix(s_i[32*c +: 32]);
    end
  end
endmodule

module aes_enc_iter #(
  parameter int KEY_BITS = 128,
  parameter bit CBC_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        block_in,
  input  logic [KEY_BITS-1:0] key,
  input  logic                mode,
  input  logic                iv_load,
  input  logic [127:0]        iv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        block_out,
  output logic                busy
);
  localparam int         NR    = (KEY_BITS == 256) ? 14 : 10;
  localparam logic [3:0] NR_M1 = 4'(NR - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_enc_iter: KEY_BITS must be 128 or 256");
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] prev, input logic [31:0] t);
    logic [127:0] n;
    n[31:0]   = prev[31:0] ^ t;
    n[63:32]  = prev[63:32] ^ n[31:0];
    n[95:64]  = prev[95:64] ^ n[63:32];
    n[127:96] = prev[127:96] ^ n[95:64];
    return n;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [3:0]          r_q, r_d;
  logic [127:0]        st_q, st_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [7:0]          rcon_q, rcon_d;
  logic                cbc_q, cbc_d;
  logic                out_valid_q, out_valid_d;
  logic [127:0]        block_out_q, block_out_d;

  logic [127:0]        sb_out, sr_out, mc_out, rk, round_val, final_val;
  logic [31:0]         kw, kw_sub, kw_t;
  logic [KEY_BITS-1:0] key_step;
  logic                rcon_adv;
  logic [127:0]        chain_in;
  logic                cbc_sel;

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (.a_i(st_q[8*i +: 8]), .s_o(sb_out[8*i +: 8]));
  end

  aes_shift_rows u_shift_rows (.s_i(sb_out), .s_o(sr_out));
  aes_mix_cols   u_mix_cols   (.s_i(sr_out), .s_o(mc_out));

  // The top word of the running key feeds the schedule's SubWord in both key sizes.
  assign kw = key_q[KEY_BITS-1 -: 32];

  for (genvar i = 0; i < 4; i++) begin : g_ksbox
    aes_sbox u_ksbox (.a_i(kw[8*i +: 8]), .s_o(kw_sub[8*i +: 8]));
  end

  if (KEY_BITS == 256) begin : g_k256
    // key_q = {k_r, k_r-1}; odd r builds even-numbered k_r+1 (RotWord + Rcon), even r plain SubWord.
    assign kw_t     = r_q[0] ? ({kw_sub[7:0], kw_sub[31:8]} ^ {24'h0, rcon_q}) : kw_sub;
    assign rk       = key_q[255:128];
    assign key_step = {expand(key_q[127:0], kw_t), key_q[255:128]};
    assign rcon_adv = r_q[0];
  end else begin : g_k128
    // key_q = k_r-1; the round key for round r is derived on the fly.
    assign kw_t     = {kw_sub[7:0], kw_sub[31:8]} ^ {24'h0, rcon_q};
    assign rk       = expand(key_q[127:0], kw_t);
    assign key_step = rk;
    assign rcon_adv = 1'b1;
  end

  assign round_val = mc_out ^ rk;
  assign final_val = sr_out ^ rk;

  if (CBC_EN) begin : g_cbc
    logic [127:0] chain_q, chain_d;

    always_comb begin
      chain_d = chain_q;
      if (state_q == ST_IDLE && iv_load) chain_d = iv;
      else if (state_q == ST_FINAL && cbc_q) chain_d = final_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain_q <= '0;
      else        chain_q <= chain_d;
    end

    // A same-cycle iv_load takes effect for the block being accepted.
    assign chain_in = mode ? (iv_load ? iv : chain_q) : '0;
    assign cbc_sel  = mode;
  end else begin : g_ecb
    assign chain_in = '0;
    assign cbc_sel  = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    st_d        = st_q;
    key_d       = key_q;
    rcon_d      = rcon_q;
    cbc_d       = cbc_q;
    out_valid_d = out_valid_q;
    block_out_d = block_out_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          st_d    = block_in ^ chain_in ^ key[127:0];
          key_d   = key;
          rcon_d  = 8'h01;
          cbc_d   = cbc_sel;
          r_d     = 4'd1;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        st_d  = round_val;
        key_d = key_step;
        if (rcon_adv) rcon_d = xtime(rcon_q);
        r_d = r_q + 4'd1;
        if (r_q == NR_M1) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        block_out_d = final_val;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      r_q         <= '0;
      st_q        <= '0;
      key_q       <= '0;
      rcon_q      <= '0;
      cbc_q       <= 1'b0;
      out_valid_q <= 1'b0;
      block_out_q <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      st_q        <= st_d;
      key_q       <= key_d;
      rcon_q      <= rcon_d;
      cbc_q       <= cbc_d;
      out_valid_q <= out_valid_d;
      block_out_q <= block_out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign block_out = block_out_q;
endmodule

// File: tb/tb_aes_enc_iter.sv
// tb/tb_aes_enc_iter.sv - scoreboard bench for aes_enc_iter (AES-128 CBC instance plus an AES-256 instance)
module tb_aes_enc_iter;
  localparam logic [127:0] K_C1    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K_C3    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] K_SP    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV_SP   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_SP1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT_SP2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CBC_CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CBC_CT2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] ECB_CT1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] ECB_CT2 = 128'hf5d3d58503b9699de785895a96fdbaaf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, mode, iv_load, out_valid, out_ready, busy;
  logic [127:0] block_in, key, iv, block_out;

  logic         w_in_valid, w_in_ready, w_mode, w_iv_load, w_out_valid, w_out_ready, w_busy;
  logic [127:0] w_block_in, w_iv, w_block_out;
  logic [255:0] w_key;

  aes_enc_iter #(.KEY_BITS(128), .CBC_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .block_in(block_in), .key(key), .mode(mode), .iv_load(iv_load), .iv(iv),
    .out_valid(out_valid), .out_ready(out_ready), .block_out(block_out), .busy(busy)
  );

  aes_enc_iter #(.KEY_BITS(256), .CBC_EN(1'b1)) dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .block_in(w_block_in), .key(w_key), .mode(w_mode), .iv_load(w_iv_load), .iv(w_iv),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .block_out(w_block_out), .busy(w_busy)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           last_acc = 0;
  logic [127:0] exp_q[$];
  logic [127:0] got;

  function automatic logic [127:0] fips(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [255:0] fips256(input logic [255:0] v);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = v[8*(31-i) +: 8];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: records accept edges and checks every output handshake against the queue.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) last_acc = cyc + 1;
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_extra: block_out=%h handshaken with nothing expected", block_out);
      end else begin
        got = exp_q.pop_front();
        if (block_out !== got) begin
          n_fail++;
          $display("FAIL scoreboard_data: block_out=%h required %h", block_out, got);
        end
      end
    end
  end

  task automatic send(input logic [127:0] pt, input logic [127:0] k, input logic m,
                      input logic ivl, input logic [127:0] v, input logic [127:0] ct, input bit push);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready_timeout: in_ready=%b required 1", in_ready);
    end
    block_in = fips(pt); key = fips(k); mode = m; iv_load = ivl; iv = fips(v); in_valid = 1'b1;
    if (push) exp_q.push_back(fips(ct));
    @(posedge clk); #1;
    in_valid = 1'b0; iv_load = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wait_out_timeout: %0d blocks pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; block_in = '0; key = '0; mode = 1'b0; iv_load = 1'b0; iv = '0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_block_in = '0; w_key = '0; w_mode = 1'b0; w_iv_load = 1'b0; w_iv = '0;
    w_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++; if (block_out !== '0) begin n_fail++; $display("FAIL reset_block_out: got %h required 0", block_out); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ecb128();
    int n = 0;
    out_ready = 1'b1;
    send(PT_C1, K_C1, 1'b0, 1'b0, '0, CT_C1, 1'b1);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ecb128_busy: busy=%b in_ready=%b required 1/0", busy, in_ready);
    end
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (n != 10) begin n_fail++; $display("FAIL ecb128_latency: %0d edges required 10", n); end
    wait_out();
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ecb128_idle: busy=%b in_ready=%b required 0/1", busy, in_ready);
    end
  endtask

  task automatic test_aes256();
    int n = 0;
    logic [127:0] exp_ct;
    n_checks++;
    if (w_in_ready !== 1'b1) begin n_fail++; $display("FAIL aes256_ready: got %b required 1", w_in_ready); end
    w_key = fips256(K_C3); w_block_in = fips(PT_C1); w_in_valid = 1'b1;
    exp_ct = fips(CT_C3);
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    while (!w_out_valid && n < 100) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (n != 14) begin n_fail++; $display("FAIL aes256_latency: %0d edges required 14", n); end
    n_checks++;
    if (w_block_out !== exp_ct) begin n_fail++; $display("FAIL aes256_data: got %h required %h", w_block_out, exp_ct); end
    @(posedge clk); #1;
    n_checks++;
    if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL aes256_handshake: out_valid=%b in_ready=%b required 0/1", w_out_valid, w_in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int first;
    out_ready = 1'b1;
    send(PT_SP1, K_SP, 1'b1, 1'b1, IV_SP, CBC_CT1, 1'b1);
    first = last_acc;
    send(PT_SP2, K_SP, 1'b1, 1'b0, '0, CBC_CT2, 1'b1);
    n_checks++;
    if (last_acc - first != 12) begin
      n_fail++;
      $display("FAIL back_to_back_spacing: %0d edges required 12", last_acc - first);
    end
    wait_out();
  endtask

  task automatic test_backpressure();
    int n = 0;
    out_ready = 1'b0;
    send(PT_SP1, K_SP, 1'b1, 1'b1, IV_SP, CBC_CT1, 1'b1);
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (n != 10) begin n_fail++; $display("FAIL bp_latency: %0d edges required 10", n); end
    for (int i = 0; i < 20; i++) begin
      key = {4{$urandom}}; block_in = {4{$urandom}}; iv = {4{$urandom}}; iv_load = ~iv_load;
      @(posedge clk); #1;
      n_checks++;
      if (block_out !== fips(CBC_CT1) || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold: cycle %0d block_out=%h in_ready=%b out_valid=%b required %h/0/1",
                 i, block_out, in_ready, out_valid, fips(CBC_CT1));
      end
    end
    iv_load = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b pending=%0d required 0/1/0",
               out_valid, in_ready, exp_q.size());
    end
    send(PT_SP2, K_SP, 1'b1, 1'b0, '0, CBC_CT2, 1'b1);
    wait_out();
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    send(PT_SP1, K_SP, 1'b1, 1'b1, IV_SP, '0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_reset: out_valid=%b in_ready=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_no_output: out_valid cycles=%0d in_ready=%b required 0/1", seen, in_ready);
    end
    // CBC with a cleared chain must equal plain ECB.
    send(PT_SP1, K_SP, 1'b1, 1'b0, '0, ECB_CT1, 1'b1);
    wait_out();
    send(PT_C1, K_C1, 1'b0, 1'b0, '0, CT_C1, 1'b1);
    wait_out();
  endtask

  task automatic test_mixed_modes();
    out_ready = 1'b1;
    send(PT_SP1, K_SP, 1'b1, 1'b1, IV_SP, CBC_CT1, 1'b1);
    send(PT_SP2, K_SP, 1'b0, 1'b0, '0, ECB_CT2, 1'b1);
    send(PT_SP2, K_SP, 1'b1, 1'b0, '0, CBC_CT2, 1'b1);
    wait_out();
  endtask

  initial begin
    test_reset();
    test_ecb128();
    test_aes256();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    test_mixed_modes();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_queue: %0d pending required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
